// File: rtl/regwb_pkg.sv
// rtl/regwb_pkg.sv - shared constants and round-robin grant helper for the register writeback arbiter
//
// Purpose : default widths, register-zero index and the rotate-priority grant
//           function used by rr_arbiter.
// Contents: ADDR_W_DEF, DATA_W_DEF, REG_ZERO, NREQ_MAX, rr_grant().
package regwb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int NREQ_MAX   = 8;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // One-hot grant to the first requester at or after ptr, wrapping modulo n.
  // Requesters at index >= n are ignored.
  function automatic logic [NREQ_MAX-1:0] rr_grant(input logic [NREQ_MAX-1:0] req,
                                                   input logic [2:0]          ptr,
                                                   input int unsigned         n);
    logic [NREQ_MAX-1:0] g;
    logic                found;
    int unsigned         idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ_MAX; k++) begin
      if (k < n) begin
        idx = 32'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[2:0]]) begin
          g[idx[2:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with rotating pointer
//
// Purpose : one-hot grant over NREQ requesters, searching from ptr upward with
//           wrap; ptr moves past the winner only when the grant is accepted.
// Ports   : clk, rst (async active-low)
//           req[NREQ]       request vector
//           stall           suppresses every grant, pointer holds
//           accept          a granted request completed its handshake
//           grant[NREQ]     one-hot grant (combinational)
//           grant_idx       binary index of the granted requester
module rr_arbiter
  import regwb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             stall,
  input  logic             accept,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NREQ_MAX-1:0] req_ext;
  logic [NREQ_MAX-1:0] grant_full;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    grant_full         = rr_grant(req_ext, 3'(ptr_q), NREQ);
    // Gating with rst keeps ready low for the whole reset interval.
    if (stall || !rst) grant = '0;
    else               grant = grant_full[NREQ-1:0];
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regwb_arbiter.sv
// rtl/regwb_arbiter.sv - round-robin writeback arbiter for the register file write port
//
// Purpose : shares the single register-file write port among NREQ requesters,
//           stages the granted write for one cycle, optionally forwards the
//           staged write onto both read ports.
// Macro   : REGWB_BYPASS_EN enables read-port forwarding of the staged write.
// Ports   : clk, rst (async active-low)
//           req_valid/req_reg/req_data/req_ready  requester handshake (packed, req 0 in LSBs)
//           wb_stall                               blocks new grants
//           regW/Wdat/RegWrite                     register file write port
//           regA/regB, Adat_rf/Bdat_rf             read indices and raw read data
//           Adat/Bdat                              read data to consumers
//           busy                                   staged write or pending request
module regwb_arbiter
  import regwb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_reg,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   wb_stall,
  output logic [ADDR_W-1:0]      regW,
  output logic [DATA_W-1:0]      Wdat,
  output logic                   RegWrite,
  input  logic [ADDR_W-1:0]      regA,
  input  logic [ADDR_W-1:0]      regB,
  input  logic [DATA_W-1:0]      Adat_rf,
  input  logic [DATA_W-1:0]      Bdat_rf,
  output logic [DATA_W-1:0]      Adat,
  output logic [DATA_W-1:0]      Bdat,
  output logic                   busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0]  grant_idx;
  logic              hs;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic [ADDR_W-1:0] regw_q, regw_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              regwrite_q, regwrite_d;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .stall     (wb_stall),
    .accept    (hs),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  assign hs       = |(req_valid & req_ready);
  assign sel_reg  = req_reg[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];

  always_comb begin
    regw_d     = regw_q;
    wdat_d     = wdat_q;
    regwrite_d = 1'b0;
    if (hs) begin
      regw_d     = sel_reg;
      wdat_d     = sel_data;
      // Writes to register zero complete the handshake but never reach the file.
      regwrite_d = (sel_reg != ADDR_W'(REG_ZERO));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regw_q     <= '0;
      wdat_q     <= '0;
      regwrite_q <= 1'b0;
    end else begin
      regw_q     <= regw_d;
      wdat_q     <= wdat_d;
      regwrite_q <= regwrite_d;
    end
  end

  assign regW     = regw_q;
  assign Wdat     = wdat_q;
  assign RegWrite = regwrite_q;
  assign busy     = regwrite_q | (|req_valid);

`ifdef REGWB_BYPASS_EN
  always_comb begin
    Adat = Adat_rf;
    Bdat = Bdat_rf;
    if (regwrite_q && (regA == regw_q) && (regA != ADDR_W'(REG_ZERO))) Adat = wdat_q;
    if (regwrite_q && (regB == regw_q) && (regB != ADDR_W'(REG_ZERO))) Bdat = wdat_q;
  end
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^{regA, regB};
  assign Adat = Adat_rf;
  assign Bdat = Bdat_rf;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// tb/tb_regwb_arbiter.sv - directed scoreboard bench for regwb_arbiter
module tb_regwb_arbiter;

  localparam int NREQ   = 3;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_reg;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   wb_stall;
  logic [ADDR_W-1:0]      regW;
  logic [DATA_W-1:0]      Wdat;
  logic                   RegWrite;
  logic [ADDR_W-1:0]      regA, regB;
  logic [DATA_W-1:0]      Adat_rf, Bdat_rf, Adat, Bdat;
  logic                   busy;

  regwb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready), .wb_stall(wb_stall), .regW(regW), .Wdat(Wdat), .RegWrite(RegWrite),
    .regA(regA), .regB(regB), .Adat_rf(Adat_rf), .Bdat_rf(Bdat_rf), .Adat(Adat), .Bdat(Bdat),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t               exp_q[$];
  logic [DATA_W-1:0] file_model [32];
  int                checks = 0;
  int                errors = 0;
  int                writes_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] r,
                         input logic [DATA_W-1:0] d);
    req_valid[i]                 = v;
    req_reg[i*ADDR_W +: ADDR_W]  = r;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic push(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    wr_t w;
    w.r = r;
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Drive just after the rising edge; sample on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every RegWrite pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      wr_t w;
      writes_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, regW}, 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("wb_reg", {27'd0, regW}, {27'd0, w.r});
        chk("wb_data", Wdat, w.d);
        file_model[regW] = Wdat;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0;
    int order [6] = '{0, 1, 2, 0, 1, 2};

    for (int i = 0; i < 32; i++) file_model[i] = '0;
    rst = 1'b0; req_valid = '0; req_reg = '0; req_data = '0; wb_stall = 1'b0;
    regA = '0; regB = '0; Adat_rf = '0; Bdat_rf = '0;

    // Reset state: ready held low even with requests pending.
    req_valid = 3'b111;
    next_cycle(); next_cycle();
    @(negedge clk);
    chk("rst_ready", {29'd0, req_ready}, 32'd0);
    chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_regW", {27'd0, regW}, 32'd0);
    chk("rst_Wdat", Wdat, 32'd0);
    req_valid = '0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Single request from requester 1.
    next_cycle();
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_ready", {29'd0, req_ready}, 32'b010);
    chk("single_busy", {31'd0, busy}, 32'd1);
    push(5'd5, 32'hDEADBEEF);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("single_regwrite", {31'd0, RegWrite}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("single_after", {31'd0, RegWrite}, 32'd0);

    // Register zero from requester 2 (ptr is 2): accepted, no write, ptr -> 0.
    next_cycle();
    set_req(2, 1'b1, 5'd0, 32'h1234);
    @(negedge clk);
    chk("r0_ready", {29'd0, req_ready}, 32'b100);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("r0_regwrite", {31'd0, RegWrite}, 32'd0);

    // Fairness from ptr=0: all three hold valid for six cycles.
    next_cycle();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(10 + i), 32'h100 + i);
    seen0 = writes_seen;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("fair_grant%0d", k), {29'd0, req_ready}, 32'(1 << order[k]));
      push(5'(10 + order[k]), 32'h100 + order[k]);
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
    @(negedge clk);
    chk("fair_pulses", writes_seen - seen0, 32'd6);

    // Staged write drains during stall; stalled request waits.
    next_cycle();
    set_req(1, 1'b1, 5'd4, 32'h44);
    @(negedge clk);
    chk("drain_ready", {29'd0, req_ready}, 32'b010);
    push(5'd4, 32'h44);
    next_cycle();
    req_valid = '0;
    wb_stall = 1'b1;
    set_req(0, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    chk("stall_drain", {31'd0, RegWrite}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_ready%0d", k), {29'd0, req_ready}, 32'd0);
      next_cycle();
      @(negedge clk);
    end
    chk("stall_noWrite", {31'd0, RegWrite}, 32'd0);
    next_cycle();
    wb_stall = 1'b0;
    @(negedge clk);
    chk("post_stall_ready", {29'd0, req_ready}, 32'b001);
    push(5'd9, 32'h99);
    next_cycle();
    req_valid = '0;
    next_cycle();

    // Reset during a staged write: the write never appears.
    set_req(2, 1'b1, 5'd6, 32'h66);
    @(negedge clk);
    chk("rstmid_ready", {29'd0, req_ready}, 32'b100);
    next_cycle();
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_regwrite", {31'd0, RegWrite}, 32'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // Read-port forwarding (ptr is 0 after reset).
    set_req(0, 1'b1, 5'd7, 32'hA5A5A5A5);
    regA = 5'd7; regB = 5'd7; Adat_rf = 32'h0; Bdat_rf = 32'h5A;
    @(negedge clk);
    chk("byp_ready", {29'd0, req_ready}, 32'b001);
    push(5'd7, 32'hA5A5A5A5);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
`ifdef REGWB_BYPASS_EN
    chk("byp_Adat", Adat, 32'hA5A5A5A5);
    chk("byp_Bdat", Bdat, 32'hA5A5A5A5);
`else
    chk("byp_Adat", Adat, 32'h0);
    chk("byp_Bdat", Bdat, 32'h5A);
`endif
    regA = 5'd8; Adat_rf = 32'h3C3C;
    #1;
    chk("byp_miss", Adat, 32'h3C3C);
    next_cycle();
    regA = 5'd7; Adat_rf = 32'h77;
    @(negedge clk);
    chk("byp_idle", Adat, 32'h77);

    // Same register from requesters 0 and 1; reset first so ptr=0.
    next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    set_req(0, 1'b1, 5'd3, 32'h11);
    set_req(1, 1'b1, 5'd3, 32'h22);
    @(negedge clk);
    chk("same_ready0", {29'd0, req_ready}, 32'b001);
    push(5'd3, 32'h11);
    next_cycle();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("same_ready1", {29'd0, req_ready}, 32'b010);
    push(5'd3, 32'h22);
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("same_final", file_model[3], 32'h22);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
